digit_scan_control: RTL and testbench

DIGIT_SCAN_CONTROL -- requirements
Module: digit_scan_control

---
 rtl/digit_scan_control.sv | 102 ++++++++++
 tb/tb_digit_scan_control.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/digit_scan_control.sv
// rtl/digit_scan_control.sv - six-digit multiplexed 7-segment scan with ghost blanking and field blink
// Optional leading-zero blanking of digit 5 is enabled by defining DIGIT_SCAN_LEADING_ZERO_BLANK_EN.
module digit_scan_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_en,
    input  logic        blink_en,
    input  logic [2:0]  adjust_mode,
    input  logic [23:0] digits,
    output logic [5:0]  digit_sel,
    output logic [6:0]  seg
);

    logic [2:0] idx;
    logic       bp;
    logic [2:0] mode_q;

    logic [3:0] cur_digit;
    logic [6:0] seg_dec;
    logic       in_field;
    logic       lz_blank;
    logic [6:0] seg_next;
    logic [5:0] sel_next;

    always_comb begin
        cur_digit = 4'd0;
        case (idx)
            3'd0: cur_digit = digits[3:0];
            3'd1: cur_digit = digits[7:4];
            3'd2: cur_digit = digits[11:8];
            3'd3: cur_digit = digits[15:12];
            3'd4: cur_digit = digits[19:16];
            3'd5: cur_digit = digits[23:20];
            default: cur_digit = 4'd0;
        endcase
    end

    always_comb begin
        seg_dec = 7'h00;
        case (cur_digit)
            4'd0: seg_dec = 7'h3F;
            4'd1: seg_dec = 7'h06;
            4'd2: seg_dec = 7'h5B;
            4'd3: seg_dec = 7'h4F;
            4'd4: seg_dec = 7'h66;
            4'd5: seg_dec = 7'h6D;
            4'd6: seg_dec = 7'h7D;
            4'd7: seg_dec = 7'h07;
            4'd8: seg_dec = 7'h7F;
            4'd9: seg_dec = 7'h6F;
            default: seg_dec = 7'h00;
        endcase
    end

    // Field membership uses the registered mode so a mode change first clears bp.
    always_comb begin
        in_field = 1'b0;
        case (mode_q)
            3'd1: in_field = (idx == 3'd5) || (idx == 3'd4);
            3'd2: in_field = (idx == 3'd3) || (idx == 3'd2);
            3'd3: in_field = (idx == 3'd1) || (idx == 3'd0);
            default: in_field = 1'b0;
        endcase
    end

    always_comb begin
`ifdef DIGIT_SCAN_LEADING_ZERO_BLANK_EN
        lz_blank = (idx == 3'd5) && (cur_digit == 4'd0) && (mode_q != 3'd1);
`else
        lz_blank = 1'b0;
`endif
        sel_next = 6'(1) << idx;
        seg_next = (bp && in_field) || lz_blank ? 7'h00 : seg_dec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= 3'd0;
            bp        <= 1'b0;
            mode_q    <= 3'd0;
            digit_sel <= 6'b0;
            seg       <= 7'b0;
        end else begin
            mode_q <= adjust_mode;
            if (adjust_mode != mode_q)
                bp <= 1'b0;
            else if (blink_en)
                bp <= ~bp;
            if (scan_en)
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            // A strobe blanks the following cycle so the old segments never ghost onto the new digit.
            if (scan_en) begin
                digit_sel <= 6'b0;
                seg       <= 7'b0;
            end else begin
                digit_sel <= sel_next;
                seg       <= seg_next;
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_control.sv
// tb/tb_digit_scan_control.sv - randomized and directed check of digit_scan_control against a behavioural model
module tb_digit_scan_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_en;
    logic        blink_en;
    logic [2:0]  adjust_mode;
    logic [23:0] digits;
    logic [5:0]  digit_sel;
    logic [6:0]  seg;

    always #5 clk = ~clk;

    digit_scan_control dut (
        .clk(clk), .reset(reset), .scan_en(scan_en), .blink_en(blink_en),
        .adjust_mode(adjust_mode), .digits(digits),
        .digit_sel(digit_sel), .seg(seg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int         m_idx  = 0;
    bit         m_bp   = 0;
    int         m_mode = 0;
    logic [5:0] exp_sel;
    logic [6:0] exp_seg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected outputs come from the rules on the values in force before the edge.
    task automatic model_edge(input bit r, input bit sc, input bit bl,
                              input logic [2:0] m, input logic [23:0] d);
        int dv;
        int lo;
        if (r) begin
            exp_sel = 0; exp_seg = 0;
            m_idx = 0; m_bp = 0; m_mode = 0;
            return;
        end
        if (sc) begin
            exp_sel = 0; exp_seg = 0;
        end else begin
            exp_sel = 6'(1 << m_idx);
            dv = int'((d >> (4 * m_idx)) & 24'hF);
            exp_seg = (dv < 10) ? seg_tbl[dv] : 7'h00;
            lo = (m_mode == 1) ? 4 : (m_mode == 2) ? 2 : (m_mode == 3) ? 0 : -1;
            if (m_bp && lo >= 0 && (m_idx == lo || m_idx == lo + 1)) exp_seg = 0;
`ifdef DIGIT_SCAN_LEADING_ZERO_BLANK_EN
            if (m_idx == 5 && dv == 0 && m_mode != 1) exp_seg = 0;
`endif
        end
        if (int'(m) != m_mode) m_bp = 0;
        else if (bl) m_bp = !m_bp;
        m_mode = int'(m);
        if (sc) m_idx = (m_idx + 1) % 6;
    endtask

    task automatic step(input bit r, input bit sc, input bit bl,
                        input logic [2:0] m, input logic [23:0] d);
        @(negedge clk);
        reset = r; scan_en = sc; blink_en = bl; adjust_mode = m; digits = d;
        @(posedge clk);
        model_edge(r, sc, bl, m, d);
        #1;
        check("digit_sel", 32'(digit_sel), 32'(exp_sel));
        check("seg", 32'(seg), 32'(exp_seg));
    endtask

    logic [23:0] rd;
    logic [2:0]  rm;

    initial begin
        reset = 1; scan_en = 0; blink_en = 0; adjust_mode = 0; digits = 0;

        step(1, 0, 0, 0, 24'h123456);
        check("reset_sel", 32'(digit_sel), 32'h0);
        step(1, 1, 1, 3'd3, 24'h123456);
        check("reset_seg", 32'(seg), 32'h0);
        step(0, 0, 0, 0, 24'h123456);
        check("first_sel", 32'(digit_sel), 32'h01);
        check("first_seg", 32'(seg), 32'h7D);

        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 0, 24'h123456);
            check("ghost_sel", 32'(digit_sel), 32'h0);
            check("ghost_seg", 32'(seg), 32'h0);
            for (int j = 0; j < 3; j++) step(0, 0, 0, 0, 24'h123456);
            check("walk_sel", 32'(digit_sel), 32'(1 << ((k + 1) % 6)));
        end

        step(0, 0, 0, 3'd2, 24'h123456);
        step(0, 0, 1, 3'd2, 24'h123456);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 3'd2, 24'h123456);
            step(0, 0, 0, 3'd2, 24'h123456);
        end

        step(0, 0, 1, 3'd1, 24'h123456);
        for (int k = 0; k < 12; k++) step(0, k % 2 == 0, 0, 3'd1, 24'h123456);

        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0, 0, 24'h0A1234);
            step(0, 0, 0, 0, 24'h0A1234);
            if (m_idx == 4) check("bad_bcd_seg", 32'(seg), 32'h0);
        end

        step(1, 0, 0, 0, 24'h123456);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0, 24'h123456);
            step(0, 0, 0, 0, 24'h123456);
        end
        step(0, 1, 0, 0, 24'h123456);
        step(1, 0, 0, 0, 24'h123456);
        check("ghost_reset_sel", 32'(digit_sel), 32'h0);
        step(0, 0, 0, 0, 24'h123456);
        check("after_reset_sel", 32'(digit_sel), 32'h01);

        rm = 0;
        for (int n = 0; n < 3000; n++) begin
            rd = 24'($urandom);
            if ($urandom_range(0, 2) == 0)
                for (int b = 0; b < 6; b++) rd[4*b +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) rm = 3'($urandom_range(0, 7));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, rm, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
